pll_lock_monitor: RTL



---
 rtl/pll_mon_if.sv | 23 ++
 rtl/pll_lock_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pll_mon_if.sv
// Signal bundle between the PLL supervisor and its environment: PLL status in,
// system-ready and measurement results out.
`timescale 1ps/1ps
interface pll_mon_if;
  logic        locked;
  logic        panel_clock;
  logic        clear_lost;
  logic        ready;
  logic        freq_ok;
  logic        lock_lost;
  logic [15:0] edge_count;
  logic [1:0]  state;

  modport master (
    output locked, panel_clock, clear_lost,
    input  ready, freq_ok, lock_lost, edge_count, state
  );

  modport slave (
    input  locked, panel_clock, clear_lost,
    output ready, freq_ok, lock_lost, edge_count, state
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// PLL supervisor: qualifies the asynchronous lock flag, counts panel_clock edges
// over fixed windows, and gates system-ready on stable lock plus in-tolerance frequency.
`timescale 1ps/1ps
module pll_lock_monitor #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int WINDOW_CYCLES      = 1250,
  parameter int EXP_EDGES          = 231,
  parameter int TOL                = 2
) (
  input  logic     clock,
  input  logic     reset_n,
  pll_mon_if.slave mon
);

  localparam int STAB_W = ($clog2(LOCK_STABLE_CYCLES) > 11) ? $clog2(LOCK_STABLE_CYCLES) : 11;
  localparam int WIN_W  = ($clog2(WINDOW_CYCLES) > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic signed [16:0] EXP_S     = 17'(EXP_EDGES);
  localparam logic signed [16:0] TOL_S     = 17'(TOL);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    MEASURE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] a, input logic inc);
    logic [16:0] s;
    s = {1'b0, a} + {16'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic in_tol(input logic [15:0] cnt);
    logic signed [16:0] diff;
    diff = $signed({1'b0, cnt}) - EXP_S;
    return (diff <= TOL_S) && (diff >= -TOL_S);
  endfunction

  logic              lock_s1_q, lock_s2_q;
  logic              pan_s1_q, pan_s2_q, pan_s3_q;
  state_e            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [15:0]       edges_q, edges_d;
  logic [15:0]       ecount_q, ecount_d;
  logic              bad_q, bad_d;
  logic              ready_q, ready_d;
  logic              freq_ok_q, freq_ok_d;
  logic              lost_q, lost_d;

  logic              locked_s;
  logic              rise;
  logic [15:0]       fin_cnt;
  logic              good;

  assign locked_s = lock_s2_q;
  assign rise     = pan_s2_q & ~pan_s3_q;
  assign fin_cnt  = sat_inc(edges_q, rise);
  assign good     = in_tol(fin_cnt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      pan_s1_q  <= 1'b0;
      pan_s2_q  <= 1'b0;
      pan_s3_q  <= 1'b0;
      state_q   <= WAIT_LOCK;
      stab_q    <= '0;
      win_q     <= '0;
      edges_q   <= '0;
      ecount_q  <= '0;
      bad_q     <= 1'b0;
      ready_q   <= 1'b0;
      freq_ok_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      lock_s1_q <= mon.locked;
      lock_s2_q <= lock_s1_q;
      pan_s1_q  <= mon.panel_clock;
      pan_s2_q  <= pan_s1_q;
      pan_s3_q  <= pan_s2_q;
      state_q   <= state_d;
      stab_q    <= stab_d;
      win_q     <= win_d;
      edges_q   <= edges_d;
      ecount_q  <= ecount_d;
      bad_q     <= bad_d;
      ready_q   <= ready_d;
      freq_ok_q <= freq_ok_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    win_d     = win_q;
    edges_d   = edges_q;
    ecount_d  = ecount_q;
    bad_d     = bad_q;
    ready_d   = ready_q;
    freq_ok_d = freq_ok_q;
    lost_d    = lost_q;

    if (mon.clear_lost) lost_d = 1'b0;

    unique case (state_q)
      WAIT_LOCK: begin
        stab_d  = '0;
        win_d   = '0;
        edges_d = '0;
        bad_d   = 1'b0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (stab_q == STAB_LAST) begin
          state_d = MEASURE;
          stab_d  = '0;
          win_d   = '0;
          edges_d = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      MEASURE, RUN: begin
        // Windows abut: the last cycle's rise is folded into the result and the
        // next window starts counting on the following cycle.
        if (win_q == WIN_LAST) begin
          win_d     = '0;
          edges_d   = '0;
          ecount_d  = fin_cnt;
          freq_ok_d = good;
          if (good) begin
            bad_d   = 1'b0;
            ready_d = 1'b1;
            state_d = RUN;
          end else if (state_q == RUN && bad_q) begin
            bad_d   = 1'b0;
            ready_d = 1'b0;
            state_d = MEASURE;
          end else if (state_q == RUN) begin
            bad_d = 1'b1;
          end
        end else begin
          win_d   = win_q + 1'b1;
          edges_d = fin_cnt;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss overrides everything; edge_count deliberately keeps its last value.
    if (state_q != WAIT_LOCK && !locked_s) begin
      state_d   = WAIT_LOCK;
      ready_d   = 1'b0;
      freq_ok_d = 1'b0;
      stab_d    = '0;
      win_d     = '0;
      edges_d   = '0;
      bad_d     = 1'b0;
      if (state_q == RUN) lost_d = 1'b1;
    end
  end

  assign mon.ready      = ready_q;
  assign mon.freq_ok    = freq_ok_q;
  assign mon.lock_lost  = lost_q;
  assign mon.edge_count = ecount_q;
  assign mon.state      = state_q;

endmodule
